// File: rtl/vga_pkg.sv
// Shared raster timing types and helpers for the VGA sync generator.
// Field widths, the timing set bundle and the generator state encoding.
package vga_pkg;

    localparam int VGA_MAX_H_WIDTH = 12;
    localparam int VGA_MAX_V_WIDTH = 11;

    typedef struct packed {
        logic [VGA_MAX_H_WIDTH-1:0] hd;
        logic [VGA_MAX_H_WIDTH-1:0] hf;
        logic [VGA_MAX_H_WIDTH-1:0] hr;
        logic [VGA_MAX_H_WIDTH-1:0] hb;
        logic [VGA_MAX_V_WIDTH-1:0] vd;
        logic [VGA_MAX_V_WIDTH-1:0] vf;
        logic [VGA_MAX_V_WIDTH-1:0] vr;
        logic [VGA_MAX_V_WIDTH-1:0] vb;
    } vga_timing_s;

    typedef enum logic {SYNC_IDLE, SYNC_RUN} sync_state_e;

    function automatic logic [VGA_MAX_H_WIDTH+1:0] h_total(
        input vga_timing_s t
    );
        return {2'b00, t.hd} + {2'b00, t.hf} +
               {2'b00, t.hr} + {2'b00, t.hb};
    endfunction

    function automatic logic [VGA_MAX_V_WIDTH+1:0] v_total(
        input vga_timing_s t
    );
        return {2'b00, t.vd} + {2'b00, t.vf} +
               {2'b00, t.vr} + {2'b00, t.vb};
    endfunction

    // Zero display or zero retrace cannot form a raster.
    function automatic logic cfg_ok(input vga_timing_s t);
        return (|t.hd) && (|t.hr) && (|t.vd) && (|t.vr);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Configuration and raster bundle between the resolution memory,
// the sync generator and the pixel pipeline.
interface vga_sync_gen_if
    import vga_pkg::*;
#(
    parameter int HW = VGA_MAX_H_WIDTH,
    parameter int VW = VGA_MAX_V_WIDTH
);
    logic          en_i;
    logic          cfg_load_i;
    logic [HW-1:0] hd_i, hf_i, hr_i, hb_i;
    logic [VW-1:0] vd_i, vf_i, vr_i, vb_i;
    logic          cfg_ack_o;
    logic          cfg_err_o;
    logic          busy_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic [HW+1:0] x_o;
    logic [VW+1:0] y_o;
    logic          line_start_o;
    logic          frame_start_o;

    modport master (
        output en_i, cfg_load_i,
        output hd_i, hf_i, hr_i, hb_i,
        output vd_i, vf_i, vr_i, vb_i,
        input  cfg_ack_o, cfg_err_o, busy_o,
        input  hsync_o, vsync_o, de_o, x_o, y_o,
        input  line_start_o, frame_start_o
    );

    modport slave (
        input  en_i, cfg_load_i,
        input  hd_i, hf_i, hr_i, hb_i,
        input  vd_i, vf_i, vr_i, vb_i,
        output cfg_ack_o, cfg_err_o, busy_o,
        output hsync_o, vsync_o, de_o, x_o, y_o,
        output line_start_o, frame_start_o
    );

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus registered display/sync flags
// evaluated on the next count so they line up with the counter output.
module vga_axis_cnt #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         i_on,
    input  logic         i_inc,
    input  logic [W-1:0] i_disp,
    input  logic [W-1:0] i_fp,
    input  logic [W-1:0] i_rt,
    input  logic [W+1:0] i_tot,
    output logic [W+1:0] o_cnt,
    output logic         o_wrap,
    output logic         o_act,
    output logic         o_sync,
    output logic         o_first
);

    logic [W+1:0] r_cnt;
    logic         r_act, r_sync, r_first;
    logic [W+1:0] w_nxt, w_lo, w_hi;

    assign w_lo   = {2'b00, i_disp} + {2'b00, i_fp};
    assign w_hi   = w_lo + {2'b00, i_rt};
    assign o_wrap = (r_cnt == i_tot - (W+2)'(1));

    always_comb begin
        w_nxt = '0;
        if (i_on) begin
            if (!i_inc)
                w_nxt = r_cnt;
            else if (!o_wrap)
                w_nxt = r_cnt + (W+2)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_cnt   <= '0;
            r_act   <= 1'b0;
            r_sync  <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_cnt   <= w_nxt;
            r_act   <= i_on && (w_nxt < {2'b00, i_disp});
            r_sync  <= i_on && (w_nxt >= w_lo) && (w_nxt < w_hi);
            r_first <= i_on && (w_nxt == '0);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_act   = r_act;
    assign o_sync  = r_sync;
    assign o_first = r_first;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator with shadow-buffered timing sets that switch
// only at frame boundaries.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter bit SYNC_ACTIVE_HIGH = 1'b1,
    parameter int HW = VGA_MAX_H_WIDTH,
    parameter int VW = VGA_MAX_V_WIDTH
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    vga_sync_gen_if.slave  bus
);

    sync_state_e   r_state;
    vga_timing_s   r_act, r_shd;
    logic          r_loaded, r_pend, r_ack, r_err;
    logic [HW+1:0] r_htot;
    logic [VW+1:0] r_vtot;

    vga_timing_s   w_in, w_nxt;
    logic          w_valid, w_bad, w_idle_ld, w_apply, w_fend, w_run;
    logic          w_h_inc, w_v_inc;
    logic          w_h_wrap, w_h_act, w_h_sync, w_h_first;
    logic          w_v_wrap, w_v_act, w_v_sync, w_v_first;
    logic [HW+1:0] w_x;
    logic [VW+1:0] w_y;

    assign w_in = '{hd: bus.hd_i, hf: bus.hf_i,
                    hr: bus.hr_i, hb: bus.hb_i,
                    vd: bus.vd_i, vf: bus.vf_i,
                    vr: bus.vr_i, vb: bus.vb_i};

    assign w_valid   = bus.cfg_load_i && cfg_ok(w_in);
    assign w_bad     = bus.cfg_load_i && !cfg_ok(w_in);
    assign w_h_inc   = (r_state == SYNC_RUN);
    assign w_v_inc   = w_h_inc && w_h_wrap;
    assign w_fend    = w_v_inc && w_v_wrap;
    assign w_idle_ld = (r_state == SYNC_IDLE) && w_valid;
    assign w_apply   = w_fend && r_pend;

    // Flags for the next cycle must follow the set that will be active then.
    assign w_nxt = w_idle_ld ? w_in : (w_apply ? r_shd : r_act);

    always_comb begin
        w_run = 1'b0;
        unique case (r_state)
            SYNC_IDLE: w_run = bus.en_i && r_loaded;
            SYNC_RUN:  w_run = !(w_fend && !bus.en_i);
            default:   w_run = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state  <= SYNC_IDLE;
            r_act    <= '0;
            r_shd    <= '0;
            r_loaded <= 1'b0;
            r_pend   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_htot   <= '0;
            r_vtot   <= '0;
        end else begin
            r_state <= w_run ? SYNC_RUN : SYNC_IDLE;
            r_ack   <= w_idle_ld || w_apply;
            r_err   <= w_bad;
            if (w_idle_ld || w_apply) begin
                r_act  <= w_nxt;
                r_htot <= h_total(w_nxt);
                r_vtot <= v_total(w_nxt);
            end
            if (w_idle_ld)
                r_loaded <= 1'b1;
            // A load in the frame-end cycle re-arms the shadow.
            if ((r_state == SYNC_RUN) && w_valid) begin
                r_shd  <= w_in;
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    vga_axis_cnt #(.W(HW)) u_h (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .i_on    (w_run),
        .i_inc   (w_h_inc),
        .i_disp  (w_nxt.hd),
        .i_fp    (w_nxt.hf),
        .i_rt    (w_nxt.hr),
        .i_tot   (r_htot),
        .o_cnt   (w_x),
        .o_wrap  (w_h_wrap),
        .o_act   (w_h_act),
        .o_sync  (w_h_sync),
        .o_first (w_h_first)
    );

    vga_axis_cnt #(.W(VW)) u_v (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .i_on    (w_run),
        .i_inc   (w_v_inc),
        .i_disp  (w_nxt.vd),
        .i_fp    (w_nxt.vf),
        .i_rt    (w_nxt.vr),
        .i_tot   (r_vtot),
        .o_cnt   (w_y),
        .o_wrap  (w_v_wrap),
        .o_act   (w_v_act),
        .o_sync  (w_v_sync),
        .o_first (w_v_first)
    );

    assign bus.busy_o        = (r_state == SYNC_RUN);
    assign bus.cfg_ack_o     = r_ack;
    assign bus.cfg_err_o     = r_err;
    assign bus.x_o           = w_x;
    assign bus.y_o           = w_y;
    assign bus.de_o          = w_h_act && w_v_act;
    assign bus.hsync_o       = SYNC_ACTIVE_HIGH ? w_h_sync : !w_h_sync;
    assign bus.vsync_o       = SYNC_ACTIVE_HIGH ? w_v_sync : !w_v_sync;
    assign bus.line_start_o  = w_h_first;
    assign bus.frame_start_o = w_h_first && w_v_first;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: small raster, mid-frame switch,
// rejected loads, en_i drop, 800x600 line timing and async reset.
module tb_vga_sync_gen;
    import vga_pkg::*;

    typedef logic [VGA_MAX_H_WIDTH-1:0] hw_t;
    typedef logic [VGA_MAX_V_WIDTH-1:0] vw_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    vga_sync_gen_if #(
        .HW(VGA_MAX_H_WIDTH),
        .VW(VGA_MAX_V_WIDTH)
    ) bus ();

    vga_sync_gen #(
        .SYNC_ACTIVE_HIGH(1'b1),
        .HW(VGA_MAX_H_WIDTH),
        .VW(VGA_MAX_V_WIDTH)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int hd, input int hf, input int hr,
                           input int hb, input int vd, input int vf,
                           input int vr, input int vb);
        bus.hd_i = hw_t'(hd);
        bus.hf_i = hw_t'(hf);
        bus.hr_i = hw_t'(hr);
        bus.hb_i = hw_t'(hb);
        bus.vd_i = vw_t'(vd);
        bus.vf_i = vw_t'(vf);
        bus.vr_i = vw_t'(vr);
        bus.vb_i = vw_t'(vb);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_start_o && n < 500);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy_o && n < 500);
    endtask

    task automatic run_frame(input int len, output int de_c,
                             output int hs_c, output int vs_c,
                             output int fs_c);
        de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0;
        for (int i = 0; i < len; i++) begin
            de_c += int'(bus.de_o);
            hs_c += int'(bus.hsync_o);
            vs_c += int'(bus.vsync_o);
            fs_c += int'(bus.frame_start_o);
            step();
        end
    endtask

    initial begin
        int n, de_c, hs_c, vs_c, fs_c, rise, fall;
        logic prev_hs;

        bus.en_i = 1'b0;
        bus.cfg_load_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_x", 32'(bus.x_o), 0);
        chk("rst_y", 32'(bus.y_o), 0);
        chk("rst_de", 32'(bus.de_o), 0);
        chk("rst_hs", 32'(bus.hsync_o), 0);
        chk("rst_vs", 32'(bus.vsync_o), 0);
        chk("rst_ack", 32'(bus.cfg_ack_o), 0);
        chk("rst_err", 32'(bus.cfg_err_o), 0);
        chk("rst_fs", 32'(bus.frame_start_o), 0);
        arstn = 1'b1;
        step();

        // Small set: Htot=8, Vtot=6
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        bus.cfg_load_i = 1'b1;
        step();
        bus.cfg_load_i = 1'b0;
        chk("t1_ack", 32'(bus.cfg_ack_o), 1);
        chk("t1_idle", 32'(bus.busy_o), 0);
        bus.en_i = 1'b1;
        step();
        chk("t1_busy", 32'(bus.busy_o), 1);
        chk("t1_ack_off", 32'(bus.cfg_ack_o), 0);
        chk("t1_ls0", 32'(bus.line_start_o), 1);
        de_c = 0; fs_c = 0;
        for (int i = 0; i < 48; i++) begin
            chk("t1_x", 32'(bus.x_o), 32'(i % 8));
            chk("t1_y", 32'(bus.y_o), 32'(i / 8));
            chk("t1_hs", 32'(bus.hsync_o),
                32'((i % 8 == 5) || (i % 8 == 6)));
            chk("t1_vs", 32'(bus.vsync_o), 32'(i / 8 == 4));
            chk("t1_de", 32'(bus.de_o),
                32'((i % 8 < 4) && (i / 8 < 3)));
            chk("t1_ls", 32'(bus.line_start_o), 32'(i % 8 == 0));
            de_c += int'(bus.de_o);
            fs_c += int'(bus.frame_start_o);
            step();
        end
        chk("t1_de_cnt", 32'(de_c), 12);
        chk("t1_fs_cnt", 32'(fs_c), 1);
        chk("t1_fs_next", 32'(bus.frame_start_o), 1);

        // Rejected load (hr=0) in RUN
        set_cfg(4, 1, 0, 1, 3, 1, 1, 1);
        bus.cfg_load_i = 1'b1;
        step();
        bus.cfg_load_i = 1'b0;
        chk("t4_err", 32'(bus.cfg_err_o), 1);
        chk("t4_noack", 32'(bus.cfg_ack_o), 0);
        chk("t4_x", 32'(bus.x_o), 1);
        step();
        chk("t4_err_pulse", 32'(bus.cfg_err_o), 0);
        wait_frame(n);
        chk("t4_frame_len", 32'(n), 46);

        // Two back-to-back loads mid-frame; only the second applies
        repeat (10) step();
        set_cfg(3, 1, 1, 1, 1, 1, 1, 1);
        bus.cfg_load_i = 1'b1;
        step();
        set_cfg(6, 2, 1, 1, 2, 1, 1, 1);
        step();
        bus.cfg_load_i = 1'b0;
        chk("t3_ack_wait", 32'(bus.cfg_ack_o), 0);
        chk("t3_err", 32'(bus.cfg_err_o), 0);
        wait_frame(n);
        chk("t3_old_len", 32'(n), 36);
        chk("t3_ack", 32'(bus.cfg_ack_o), 1);
        chk("t3_x0", 32'(bus.x_o), 0);
        chk("t3_y0", 32'(bus.y_o), 0);
        run_frame(50, de_c, hs_c, vs_c, fs_c);
        chk("t3_de_cnt", 32'(de_c), 12);
        chk("t3_hs_cnt", 32'(hs_c), 5);
        chk("t3_vs_cnt", 32'(vs_c), 10);
        chk("t3_fs_cnt", 32'(fs_c), 1);
        chk("t3_fs_50", 32'(bus.frame_start_o), 1);
        chk("t3_ack_once", 32'(bus.cfg_ack_o), 0);

        // en_i dropped at y=1: frame completes, then IDLE
        repeat (10) step();
        chk("t5_y1", 32'(bus.y_o), 1);
        bus.en_i = 1'b0;
        wait_idle(n);
        chk("t5_tail", 32'(n), 40);
        chk("t5_busy", 32'(bus.busy_o), 0);
        chk("t5_hs", 32'(bus.hsync_o), 0);
        chk("t5_vs", 32'(bus.vsync_o), 0);
        chk("t5_de", 32'(bus.de_o), 0);
        chk("t5_x", 32'(bus.x_o), 0);

        // 800x600 line timing
        set_cfg(800, 40, 128, 88, 600, 1, 4, 23);
        bus.cfg_load_i = 1'b1;
        step();
        bus.cfg_load_i = 1'b0;
        chk("t2_ack", 32'(bus.cfg_ack_o), 1);
        bus.en_i = 1'b1;
        step();
        chk("t2_busy", 32'(bus.busy_o), 1);
        chk("t2_fs", 32'(bus.frame_start_o), 1);
        rise = -1; fall = -1; de_c = 0; prev_hs = 1'b0;
        for (int i = 0; i < 1056; i++) begin
            if (bus.hsync_o && !prev_hs) rise = int'(bus.x_o);
            if (!bus.hsync_o && prev_hs) fall = int'(bus.x_o);
            prev_hs = bus.hsync_o;
            de_c += int'(bus.de_o);
            step();
        end
        chk("t2_hs_rise", 32'(rise), 840);
        chk("t2_hs_fall", 32'(fall), 968);
        chk("t2_de_line", 32'(de_c), 800);
        chk("t2_x_wrap", 32'(bus.x_o), 0);
        chk("t2_y1", 32'(bus.y_o), 1);
        chk("t2_ls", 32'(bus.line_start_o), 1);
        chk("t2_fs_off", 32'(bus.frame_start_o), 0);
        chk("t2_vs", 32'(bus.vsync_o), 0);

        // Async reset mid-line
        repeat (100) step();
        chk("t6_x", 32'(bus.x_o), 100);
        chk("t6_de", 32'(bus.de_o), 1);
        #2 arstn = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy_o), 0);
        chk("t6_x0", 32'(bus.x_o), 0);
        chk("t6_y0", 32'(bus.y_o), 0);
        chk("t6_de0", 32'(bus.de_o), 0);
        chk("t6_hs0", 32'(bus.hsync_o), 0);
        chk("t6_ls0", 32'(bus.line_start_o), 0);
        #2 arstn = 1'b1;
        repeat (5) step();
        chk("t6_stay_idle", 32'(bus.busy_o), 0);
        chk("t6_no_ack", 32'(bus.cfg_ack_o), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Downstream consumer of the resolution memory's timing parameters: hd/hf/hr/hb, vd/vf/vr/vb and the valid indication.
- Generates the pixel-clock-domain raster: horizontal/vertical counters, hsync, vsync, display-enable and frame/line strobes.
- Timing sets are shadow-buffered and applied only at frame boundaries, so a resolution change never produces a torn frame.
- Sits between the resolution memory and the pixel/colour pipeline feeding the DAC.

Parameters:
SYNC_ACTIVE_HIGH, 1, sync polarity: 1 = hsync_o/vsync_o high during retrace, 0 = low.
HW, VGA_MAX_H_WIDTH (vga_pkg), width of horizontal timing fields.
VW, VGA_MAX_V_WIDTH (vga_pkg), width of vertical timing fields.

Ports:
clk_i  in  1  pixel clock; single clock domain.
arstn_i  in  1  asynchronous active-low reset.
en_i  in  1  run request: level; generator runs while high.
cfg_load_i  in  1  one-cycle pulse: capture hd_i..vb_i.
hd_i, hf_i, hr_i, hb_i  in  HW each  horizontal display, front porch, retrace, back porch.
vd_i, vf_i, vr_i, vb_i  in  VW each  vertical display, front porch, retrace, back porch.
cfg_ack_o  out  1  pulse: captured set now active.
cfg_err_o  out  1  pulse: load rejected.
busy_o  out  1  state is RUN.
hsync_o, vsync_o  out  1  sync outputs, polarity per SYNC_ACTIVE_HIGH.
de_o  out  1  display enable.
x_o  out  HW+2  horizontal counter.
y_o  out  VW+2  vertical counter.
line_start_o, frame_start_o  out  1  strobes at x=0 and at x=0,y=0.

Behaviour:
Reset (async, arstn_i low):
- State IDLE; counters 0; de_o, strobes, cfg_ack_o, cfg_err_o and busy_o all 0.
- hsync_o/vsync_o at their inactive level.
- Active and shadow sets cleared; loaded flag 0; pending flag 0.
- Reset mid-frame aborts immediately; the pending set is discarded.

Config validation:
- cfg_load_i with hd, hr, vd or vr equal to 0 is rejected.
- On rejection: cfg_err_o pulses 1 cycle later; nothing is captured; pending and active sets are unchanged.

Derived totals:
- Htot = hd+hf+hr+hb, computed at HW+2 bits; Vtot likewise at VW+2 bits; no overflow possible.
- Totals are recomputed only when a set becomes active.

State IDLE:
- A valid cfg_load_i writes the active set directly, sets loaded, and pulses cfg_ack_o the next cycle.
- Transition to RUN when en_i=1 and loaded=1.
- The first RUN cycle presents x=0, y=0, frame_start_o=1, line_start_o=1.

State RUN:
- x increments every cycle. At x=Htot-1, x wraps to 0 and y increments. At y=Vtot-1 with x=Htot-1, y wraps to 0 (frame end).
- A valid cfg_load_i writes the shadow set and sets pending. A later load overwrites the shadow; last write wins.
- At frame end with pending=1: shadow is copied to active, pending is cleared, and cfg_ack_o pulses in the same cycle that x=y=0 under the new set.
- At frame end with en_i=0: go to IDLE and drive outputs inactive. en_i falling mid-frame completes the current frame.
- cfg_load_i in the frame-end cycle is captured into the shadow and applied at the following frame end.

Outputs (registered, all aligned with x_o/y_o of the same cycle):
- de_o = (x<hd) and (y<vd).
- hsync active when hd+hf <= x < hd+hf+hr.
- vsync active when vd+vf <= y < vd+vf+vr; it is line-based, so it changes at x=0.
- hf, hb, vf and vb may each be 0; the sync windows then start or end at the adjusted boundary with no glitch.
- busy_o = (state==RUN).

Decomposition:
vga_pkg:
- Add vga_timing_s packed struct (the 8 fields) for the active and shadow registers.
- Add the sync_state_e enum {SYNC_IDLE, SYNC_RUN}.
- Reuse VGA_MAX_H_WIDTH and VGA_MAX_V_WIDTH.

Sub-module vga_axis_cnt:
- Parameterised by width; instantiated twice (horizontal and vertical).
- Inputs: enable, display, front porch and retrace fields.
- Outputs: counter, wrap flag, active-display flag, sync-window flag.

Test Plan:
1. Small set hd=4,hf=1,hr=2,hb=1, vd=3,vf=1,vr=1,vb=1; load, then en_i=1 -> cfg_ack_o after 1 cycle. Htot=8, Vtot=6, frame = 48 cycles. hsync active at x=5,6. vsync active for y=4. de_o high 12 cycles per frame. frame_start_o every 48 cycles.
2. 800x600 set (800/40/128/88, 600/1/4/23) -> line 1056 cycles. hsync active x=840..967. vsync active y=601..604. Frame 663168 cycles. 480000 de_o cycles per frame.
3. Mid-frame load of a second set (hd=6,hf=2,hr=1,hb=1, vd=2,vf=1,vr=1,vb=1) -> old timing continues to frame end. cfg_ack_o coincides with the first x=y=0 cycle of the new set. Next frame is 10*5=50 cycles.
4. Load with hr=0 -> cfg_err_o pulse, cfg_ack_o silent, timing unchanged. Two back-to-back valid loads in RUN -> only the second is applied.
5. en_i dropped at y=1 -> frame completes, then busy_o=0 and hsync_o, vsync_o and de_o go inactive.
6. arstn_i asserted mid-line -> same-cycle async clear of all outputs. After release with en_i=1 and no new load -> stays IDLE (loaded=0).
